// File: rtl/clk_divider_prog.sv
// ---------------------------------------------------------------------------
// clk_divider_prog
//
// Runtime-programmable single-channel clock divider. Generates a 50%-duty
// derived clock from i_clk whose half-period (in i_clk cycles) can be
// reloaded while running. Supports free-run, graceful stop, abort and
// N-pulse burst modes. Every output is driven straight from a flop.
//
// Ports:
//   i_clk        system clock
//   i_reset_n    synchronous active-low reset
//   i_start_stb  start free-run (1-cycle strobe)
//   i_burst_stb  start a burst of i_burst_len rising edges
//   i_burst_len  burst length, sampled with i_burst_stb (0 = ignored)
//   i_stop_stb   graceful stop (never shortens a low phase)
//   i_abort_stb  immediate stop (may truncate a low phase)
//   i_div_load   load a new half-period
//   i_div_half   new half-period, sampled with i_div_load (0 stored as 1)
//   o_div_clk    divided clock, idles high
//   o_rose       one-cycle pulse coincident with a 0->1 of o_div_clk
//   o_fell       one-cycle pulse coincident with a 1->0 of o_div_clk
//   o_busy       divider is not idle
//   o_done       one-cycle pulse on every return to idle (not on reset)
// ---------------------------------------------------------------------------
module clk_divider_prog #(
    parameter int WIDTH        = 12,
    parameter int DEFAULT_HALF = 2604,
    parameter int BURST_WIDTH  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_start_stb,
    input  logic                   i_burst_stb,
    input  logic [BURST_WIDTH-1:0] i_burst_len,
    input  logic                   i_stop_stb,
    input  logic                   i_abort_stb,
    input  logic                   i_div_load,
    input  logic [WIDTH-1:0]       i_div_half,
    output logic                   o_div_clk,
    output logic                   o_rose,
    output logic                   o_fell,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BURST,
        STOPPING
    } state_t;

    localparam logic [WIDTH-1:0]       HP_DEFAULT  = WIDTH'(DEFAULT_HALF);
    localparam logic [WIDTH-1:0]       CNT_DEFAULT = WIDTH'(DEFAULT_HALF - 1);
    localparam logic [WIDTH-1:0]       ONE         = WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] REM_ONE     = BURST_WIDTH'(1);

    state_t                 state, state_next;
    logic [WIDTH-1:0]       hp, hp_next;
    logic [WIDTH-1:0]       pending, pending_next;
    logic                   pend_flag, pend_flag_next;
    logic [WIDTH-1:0]       cnt, cnt_next;
    logic [BURST_WIDTH-1:0] rem, rem_next;
    logic                   div_clk, div_clk_next;
    logic                   rose_q, rose_next;
    logic                   fell_q, fell_next;
    logic                   busy_q, busy_next;
    logic                   done_q, done_next;
    logic [WIDTH-1:0]       load_val;
    logic [WIDTH-1:0]       rise_hp;

    // A requested half-period of zero would never toggle; clamp it to one.
    assign load_val = (i_div_half == '0) ? ONE : i_div_half;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            hp        <= HP_DEFAULT;
            pending   <= '0;
            pend_flag <= 1'b0;
            cnt       <= CNT_DEFAULT;
            rem       <= '0;
            div_clk   <= 1'b1;
            rose_q    <= 1'b0;
            fell_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            hp        <= hp_next;
            pending   <= pending_next;
            pend_flag <= pend_flag_next;
            cnt       <= cnt_next;
            rem       <= rem_next;
            div_clk   <= div_clk_next;
            rose_q    <= rose_next;
            fell_q    <= fell_next;
            busy_q    <= busy_next;
            done_q    <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        hp_next        = hp;
        pending_next   = pending;
        pend_flag_next = pend_flag;
        cnt_next       = cnt;
        rem_next       = rem;
        div_clk_next   = div_clk;
        rose_next      = 1'b0;
        fell_next      = 1'b0;
        done_next      = 1'b0;
        rise_hp        = hp;

        if (i_div_load) begin
            pending_next   = load_val;
            pend_flag_next = 1'b1;
        end

        if (state == IDLE) begin
            // Nothing is toggling, so a new half-period can take effect at once.
            if (i_div_load) begin
                hp_next        = load_val;
                pend_flag_next = 1'b0;
            end else if (pend_flag) begin
                hp_next        = pending;
                pend_flag_next = 1'b0;
            end
            // Stop/abort outrank start/burst even though they do nothing here.
            if (!i_abort_stb && !i_stop_stb) begin
                if (i_burst_stb && (i_burst_len != '0)) begin
                    state_next = BURST;
                    rem_next   = i_burst_len;
                    cnt_next   = hp_next - ONE;
                end else if (i_start_stb) begin
                    state_next = RUN;
                    cnt_next   = hp_next - ONE;
                end
            end
        end else if (i_abort_stb) begin
            state_next   = IDLE;
            div_clk_next = 1'b1;
            cnt_next     = hp - ONE;
            done_next    = 1'b1;
        end else if (i_stop_stb && (state != STOPPING) && div_clk) begin
            // Stopping while high: freeze high, suppressing any pending fall.
            state_next = IDLE;
            done_next  = 1'b1;
        end else begin
            if (i_stop_stb && (state != STOPPING)) begin
                state_next = STOPPING;
            end
            if (cnt == '0) begin
                if (div_clk) begin
                    div_clk_next = 1'b0;
                    fell_next    = 1'b1;
                    cnt_next     = hp - ONE;
                end else begin
                    // A pending half-period is applied only at a rising edge so
                    // every emitted period is uniform.
                    if (pend_flag) begin
                        rise_hp        = pending;
                        hp_next        = pending;
                        pend_flag_next = i_div_load;
                    end
                    cnt_next     = rise_hp - ONE;
                    div_clk_next = 1'b1;
                    rose_next    = 1'b1;
                    if (state_next == STOPPING) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if (state == BURST) begin
                        if (rem == REM_ONE) begin
                            rem_next   = '0;
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            rem_next = rem - REM_ONE;
                        end
                    end
                end
            end else begin
                cnt_next = cnt - ONE;
            end
        end

        busy_next = (state_next != IDLE);
    end

    assign o_div_clk = div_clk;
    assign o_rose    = rose_q;
    assign o_fell    = fell_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_divider_prog
//
// Directed self-checking bench for clk_divider_prog with default parameters.
// Cycle numbering: cycle 0 is the cycle in which a strobe is driven; the
// DUT reacts on the following edge, so its response is visible in cycle 1.
// Edge times of o_fell/o_rose/o_done are recorded into queues and compared
// against hand-computed cycle numbers.
// ---------------------------------------------------------------------------
module tb_clk_divider_prog;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_start_stb;
    logic        i_burst_stb;
    logic [7:0]  i_burst_len;
    logic        i_stop_stb;
    logic        i_abort_stb;
    logic        i_div_load;
    logic [11:0] i_div_half;
    logic        o_div_clk;
    logic        o_rose;
    logic        o_fell;
    logic        o_busy;
    logic        o_done;

    int errors;
    int checks;
    int cyc;
    int fellQ[$];
    int roseQ[$];
    int doneQ[$];

    clk_divider_prog dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_start_stb (i_start_stb),
        .i_burst_stb (i_burst_stb),
        .i_burst_len (i_burst_len),
        .i_stop_stb  (i_stop_stb),
        .i_abort_stb (i_abort_stb),
        .i_div_load  (i_div_load),
        .i_div_half  (i_div_half),
        .o_div_clk   (o_div_clk),
        .o_rose      (o_rose),
        .o_fell      (o_fell),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int qAt(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // Advance one cycle, sample 1 time unit after the rising edge.
    task automatic stepCycle();
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_fell) fellQ.push_back(cyc);
        if (o_rose) roseQ.push_back(cyc);
        if (o_done) doneQ.push_back(cyc);
    endtask

    task automatic runFor(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic markZero();
        cyc = 0;
        fellQ.delete();
        roseQ.delete();
        doneQ.delete();
    endtask

    // Drive the given strobes for exactly one cycle.
    task automatic applyStimulus(input logic start, input logic burst, input logic stop,
                                 input logic abort, input logic load,
                                 input logic [7:0] blen, input logic [11:0] half);
        i_start_stb = start;
        i_burst_stb = burst;
        i_stop_stb  = stop;
        i_abort_stb = abort;
        i_div_load  = load;
        i_burst_len = blen;
        i_div_half  = half;
        stepCycle();
        i_start_stb = 1'b0;
        i_burst_stb = 1'b0;
        i_stop_stb  = 1'b0;
        i_abort_stb = 1'b0;
        i_div_load  = 1'b0;
        i_burst_len = '0;
        i_div_half  = '0;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        i_reset_n   = 1'b0;
        i_start_stb = 1'b0;
        i_burst_stb = 1'b0;
        i_burst_len = '0;
        i_stop_stb  = 1'b0;
        i_abort_stb = 1'b0;
        i_div_load  = 1'b0;
        i_div_half  = '0;

        // Reset values
        runFor(3);
        checkOutput("rst_clk",  o_div_clk, 1);
        checkOutput("rst_rose", o_rose,    0);
        checkOutput("rst_fell", o_fell,    0);
        checkOutput("rst_busy", o_busy,    0);
        checkOutput("rst_done", o_done,    0);
        i_reset_n = 1'b1;
        runFor(2);

        // Free run, hp=3
        applyStimulus(0, 0, 0, 0, 1, 8'd0, 12'd3);
        markZero();
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 12'd0);
        checkOutput("run_busy1", o_busy, 1);
        checkOutput("run_clk1",  o_div_clk, 1);
        runFor(9);
        checkOutput("run_fell0", qAt(fellQ, 0), 4);
        checkOutput("run_rose0", qAt(roseQ, 0), 7);
        checkOutput("run_fell1", qAt(fellQ, 1), 10);
        checkOutput("run_clk10", o_div_clk, 0);

        // Load 5 while low: current low phase unaffected
        applyStimulus(0, 0, 0, 0, 1, 8'd0, 12'd5);
        runFor(12);
        checkOutput("ld5_rose1", qAt(roseQ, 1), 13);
        checkOutput("ld5_fell2", qAt(fellQ, 2), 18);
        checkOutput("ld5_rose2", qAt(roseQ, 2), 23);

        // Load 0 while high: becomes hp=1 at the next rise
        applyStimulus(0, 0, 0, 0, 1, 8'd0, 12'd0);
        runFor(12);
        checkOutput("ld0_fell3", qAt(fellQ, 3), 28);
        checkOutput("ld0_rose3", qAt(roseQ, 3), 33);
        checkOutput("ld0_fell4", qAt(fellQ, 4), 34);
        checkOutput("ld0_rose4", qAt(roseQ, 4), 35);
        checkOutput("ld0_fell5", qAt(fellQ, 5), 36);
        runFor(1);
        checkOutput("ld0_clk37", o_div_clk, 1);

        // Stop while high (fall would otherwise occur on this same edge)
        applyStimulus(0, 0, 1, 0, 0, 8'd0, 12'd0);
        checkOutput("stopHi_done", o_done,    1);
        checkOutput("stopHi_busy", o_busy,    0);
        checkOutput("stopHi_clk",  o_div_clk, 1);
        checkOutput("stopHi_fell", o_fell,    0);
        runFor(3);
        checkOutput("stopHi_nfell", fellQ.size(), 6);
        checkOutput("stopHi_ndone", doneQ.size(), 1);
        checkOutput("stopHi_clk41", o_div_clk, 1);

        // Burst hp=2, len=2
        applyStimulus(0, 0, 0, 0, 1, 8'd0, 12'd2);
        markZero();
        applyStimulus(0, 1, 0, 0, 0, 8'd2, 12'd0);
        runFor(11);
        checkOutput("bst_fell0", qAt(fellQ, 0), 3);
        checkOutput("bst_rose0", qAt(roseQ, 0), 5);
        checkOutput("bst_fell1", qAt(fellQ, 1), 7);
        checkOutput("bst_rose1", qAt(roseQ, 1), 9);
        checkOutput("bst_nrose", roseQ.size(), 2);
        checkOutput("bst_done",  qAt(doneQ, 0), 9);
        checkOutput("bst_ndone", doneQ.size(), 1);
        checkOutput("bst_clk",   o_div_clk, 1);
        checkOutput("bst_busy",  o_busy, 0);

        // Burst of length 0 is ignored
        applyStimulus(0, 1, 0, 0, 0, 8'd0, 12'd0);
        checkOutput("bst0_busy", o_busy, 0);

        // Stop while low, hp=4, one cycle into the low phase
        applyStimulus(0, 0, 0, 0, 1, 8'd0, 12'd4);
        markZero();
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 12'd0);
        runFor(5);
        applyStimulus(0, 0, 1, 0, 0, 8'd0, 12'd0);
        checkOutput("stopLo_busy7", o_busy, 1);
        runFor(4);
        checkOutput("stopLo_fell", qAt(fellQ, 0), 5);
        checkOutput("stopLo_rose", qAt(roseQ, 0), 9);
        checkOutput("stopLo_done", qAt(doneQ, 0), 9);
        checkOutput("stopLo_busy", o_busy, 0);
        checkOutput("stopLo_clk",  o_div_clk, 1);

        // Abort during low phase
        markZero();
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 12'd0);
        runFor(5);
        checkOutput("abt_clkLow", o_div_clk, 0);
        applyStimulus(0, 0, 0, 1, 0, 8'd0, 12'd0);
        checkOutput("abt_clk",  o_div_clk, 1);
        checkOutput("abt_rose", o_rose, 0);
        checkOutput("abt_done", o_done, 1);
        checkOutput("abt_busy", o_busy, 0);

        // Abort together with start from IDLE
        markZero();
        applyStimulus(1, 0, 0, 1, 0, 8'd0, 12'd0);
        checkOutput("abtSt_busy", o_busy, 0);
        checkOutput("abtSt_done", o_done, 0);
        runFor(6);
        checkOutput("abtSt_nfell", fellQ.size(), 0);

        // Reset mid-burst during a low phase, with a half-period pending
        applyStimulus(0, 0, 0, 0, 1, 8'd0, 12'd2);
        markZero();
        applyStimulus(0, 1, 0, 0, 0, 8'd5, 12'd0);
        applyStimulus(0, 0, 0, 0, 1, 8'd0, 12'd7);
        runFor(1);
        checkOutput("rstB_clkLow", o_div_clk, 0);
        i_reset_n = 1'b0;
        stepCycle();
        checkOutput("rstB_clk",  o_div_clk, 1);
        checkOutput("rstB_rose", o_rose, 0);
        checkOutput("rstB_fell", o_fell, 0);
        checkOutput("rstB_busy", o_busy, 0);
        checkOutput("rstB_done", o_done, 0);
        i_reset_n = 1'b1;
        markZero();
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 12'd0);
        runFor(2605);
        checkOutput("rstB_fell0", qAt(fellQ, 0), 2605);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
